game_objects_axi_slave: RTL and testbench

AXI4-Lite slave register file for the game-objects IP. It terminates the S00_AXI bus driven by the processor or the AXI master VIP. It holds four 32-bit object registers (paddle/ball state) and presents them to the pixel/game logic. The block is the responder end of the AXI4-Lite write/read traffic that software issues to offsets 0x0–0xC.

---
 rtl/game_objects_pkg.sv | 42 ++++
 rtl/game_objects_axi_slave_if.sv | 37 +++
 rtl/game_objects_shadow.sv | 27 ++
 rtl/game_objects_axi_slave.sv | 164 ++++++++++++++++
 tb/tb_game_objects_axi_slave.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_objects_pkg.sv
// Shared types and constants for the game-objects AXI4-Lite register file.
package game_objects_pkg;

   localparam int unsigned DATA_W       = 32;
   localparam int unsigned ADDR_W       = 4;
   localparam int unsigned STRB_W       = DATA_W / 8;
   localparam int unsigned NUM_OBJ_REGS = 4;
   localparam int unsigned IDX_W        = 2;
   localparam int unsigned OBJ_W        = NUM_OBJ_REGS * DATA_W;

   localparam logic [ADDR_W-1:0] REG_PADDLE_L = 4'h0;
   localparam logic [ADDR_W-1:0] REG_PADDLE_R = 4'h4;
   localparam logic [ADDR_W-1:0] REG_BALL_X   = 4'h8;
   localparam logic [ADDR_W-1:0] REG_BALL_Y   = 4'hC;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {IDLE, PARTIAL, COMMIT, RESP} wr_state_t;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
   } wr_req_t;

   // Word select from a byte address; the low two bits are ignored.
   function automatic logic [IDX_W-1:0] reg_index(input logic [ADDR_W-1:0] addr);
      return addr[3:2];
   endfunction

   function automatic logic [DATA_W-1:0] merge_strb(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] r;
      r = old_v;
      for (int unsigned b = 0; b < STRB_W; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/game_objects_axi_slave_if.sv
// AXI4-Lite bus bundle between the processor/VIP master and the register file.
interface game_objects_axi_slave_if;
   import game_objects_pkg::*;

   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/game_objects_shadow.sv
// Frame-latched copy of the object registers; used only when GAME_OBJ_SHADOW_EN is defined.
module game_objects_shadow
   import game_objects_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [OBJ_W-1:0] live,
   output logic [OBJ_W-1:0] shadow
);

   logic [OBJ_W-1:0] shadow_q;
   logic [OBJ_W-1:0] shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      if (load) shadow_d = live;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shadow_q <= '0;
      else        shadow_q <= shadow_d;
   end

   assign shadow = shadow_q;

endmodule

// File: rtl/game_objects_axi_slave.sv
// AXI4-Lite slave holding four 32-bit paddle/ball registers for the game logic.
// GAME_OBJ_SHADOW_EN: obj_regs is a copy refreshed only on frame_tick.
module game_objects_axi_slave
   import game_objects_pkg::*;
(
   input  logic                     S_AXI_ACLK,
   input  logic                     S_AXI_ARESETN,
   game_objects_axi_slave_if.slave  s_axi,
   input  logic                     frame_tick,
   output logic [OBJ_W-1:0]         obj_regs,
   output logic [NUM_OBJ_REGS-1:0]  obj_wr_pulse
);

   wr_state_t                 state_q,    state_d;
   logic                      rst_done_q, rst_done_d;
   logic                      aw_held_q,  aw_held_d;
   logic                      w_held_q,   w_held_d;
   wr_req_t                   req_q,      req_d;
   logic                      awready_q,  awready_d;
   logic                      wready_q,   wready_d;
   logic                      bvalid_q,   bvalid_d;
   logic                      arready_q,  arready_d;
   logic                      rvalid_q,   rvalid_d;
   logic [DATA_W-1:0]         rdata_q,    rdata_d;
   logic [DATA_W-1:0]         regs_q [NUM_OBJ_REGS];
   logic [DATA_W-1:0]         regs_d [NUM_OBJ_REGS];
   logic [NUM_OBJ_REGS-1:0]   pulse_q,    pulse_d;

   logic aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
   logic [OBJ_W-1:0] live_c;

   assign aw_hs_c = rst_done_q & s_axi.awvalid & awready_q;
   assign w_hs_c  = rst_done_q & s_axi.wvalid  & wready_q;
   assign b_hs_c  = bvalid_q   & s_axi.bready;
   assign ar_hs_c = rst_done_q & s_axi.arvalid & arready_q;
   assign r_hs_c  = rvalid_q   & s_axi.rready;

   assign rst_done_d = 1'b1;

   // Write path: capture AW/W independently, commit one edge after both are held.
   always_comb begin
      state_d   = state_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      req_d     = req_q;
      bvalid_d  = bvalid_q;
      regs_d    = regs_q;
      pulse_d   = '0;

      if (aw_hs_c) begin
         aw_held_d = 1'b1;
         req_d.idx = reg_index(s_axi.awaddr);
      end
      if (w_hs_c) begin
         w_held_d   = 1'b1;
         req_d.data = s_axi.wdata;
         req_d.strb = s_axi.wstrb;
      end

      unique case (state_q)
         IDLE, PARTIAL: begin
            if (aw_held_d && w_held_d)      state_d = COMMIT;
            else if (aw_held_d || w_held_d) state_d = PARTIAL;
         end
         COMMIT: begin
            regs_d[req_q.idx]  = merge_strb(regs_q[req_q.idx], req_q.data, req_q.strb);
            pulse_d[req_q.idx] = 1'b1;
            aw_held_d          = 1'b0;
            w_held_d           = 1'b0;
            bvalid_d           = 1'b1;
            state_d            = RESP;
         end
         RESP: begin
            if (b_hs_c) begin
               bvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      awready_d = rst_done_d & ~aw_held_d & ~bvalid_d;
      wready_d  = rst_done_d & ~w_held_d  & ~bvalid_d;
   end

   // Read path: regs_q is the pre-commit value, so a colliding read sees old data.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (ar_hs_c) begin
         rvalid_d = 1'b1;
         rdata_d  = regs_q[reg_index(s_axi.araddr)];
      end else if (r_hs_c) begin
         rvalid_d = 1'b0;
      end
      arready_d = rst_done_d & ~rvalid_d;
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q    <= IDLE;
         rst_done_q <= 1'b0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         req_q      <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         regs_q     <= '{default: '0};
         pulse_q    <= '0;
      end else begin
         state_q    <= state_d;
         rst_done_q <= rst_done_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         req_q      <= req_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         regs_q     <= regs_d;
         pulse_q    <= pulse_d;
      end
   end

   always_comb begin
      live_c = '0;
      for (int unsigned i = 0; i < NUM_OBJ_REGS; i++) begin
         live_c[i*DATA_W +: DATA_W] = regs_q[i];
      end
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = RESP_OKAY;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = RESP_OKAY;
   assign obj_wr_pulse  = pulse_q;

   logic unused_ok;

`ifdef GAME_OBJ_SHADOW_EN
   game_objects_shadow u_shadow (
      .clk    (S_AXI_ACLK),
      .rst_n  (S_AXI_ARESETN),
      .load   (frame_tick),
      .live   (live_c),
      .shadow (obj_regs)
   );
   assign unused_ok = ^{s_axi.awprot, s_axi.arprot};
`else
   assign obj_regs  = live_c;
   assign unused_ok = ^{s_axi.awprot, s_axi.arprot, frame_tick};
`endif

endmodule

// File: tb/tb_game_objects_axi_slave.sv
// Directed bench for game_objects_axi_slave with a transaction-level reference model.
module tb_game_objects_axi_slave;
   import game_objects_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic frame_tick = 1'b0;
   logic [OBJ_W-1:0]        obj_regs;
   logic [NUM_OBJ_REGS-1:0] obj_wr_pulse;

   game_objects_axi_slave_if axi();

   game_objects_axi_slave dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .s_axi         (axi),
      .frame_tick    (frame_tick),
      .obj_regs      (obj_regs),
      .obj_wr_pulse  (obj_wr_pulse)
   );

   always #5 clk = ~clk;

   int passes = 0;
   int checks = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   logic [3:0] last_pulse = 4'h0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && obj_wr_pulse != 4'h0) begin
         pulse_cnt  <= pulse_cnt + 1;
         last_pulse <= obj_wr_pulse;
      end
   end

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
   endtask

   task automatic timeout_fail(input string nm);
      checks++;
      $display("FAIL %s: got no handshake, required one within budget", nm);
   endtask

   // Reference model: registers plus outstanding-transaction bookkeeping.
   logic [31:0]  m_regs [4];
   logic [127:0] m_shadow;
   logic         m_aw_h, m_w_h, m_bv, m_rv;
   logic [1:0]   m_idx;
   logic [31:0]  m_data, m_rd;
   logic [3:0]   m_strb, m_pulse;

   function automatic logic [127:0] pack_regs();
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[i*32 +: 32] = m_regs[i];
      return r;
   endfunction

   function automatic logic [127:0] exp_obj();
`ifdef GAME_OBJ_SHADOW_EN
      return m_shadow;
`else
      return pack_regs();
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
         m_shadow = '0;
         m_aw_h = 1'b0; m_w_h = 1'b0; m_bv = 1'b0; m_rv = 1'b0;
         m_idx = 2'd0; m_data = 32'h0; m_rd = 32'h0; m_strb = 4'h0; m_pulse = 4'h0;
      end else begin
         m_pulse = 4'h0;
         if (m_bv && axi.bready) m_bv = 1'b0;
         if (m_rv && axi.rready) m_rv = 1'b0;
         if (axi.arvalid && axi.arready) begin
            m_rv = 1'b1;
            m_rd = m_regs[axi.araddr[3:2]];
         end
`ifdef GAME_OBJ_SHADOW_EN
         if (frame_tick) m_shadow = pack_regs();
`endif
         if (m_aw_h && m_w_h) begin
            for (int b = 0; b < 4; b++)
               if (m_strb[b]) m_regs[m_idx][8*b +: 8] = m_data[8*b +: 8];
            m_pulse[m_idx] = 1'b1;
            m_bv = 1'b1;
            m_aw_h = 1'b0;
            m_w_h = 1'b0;
         end
         if (axi.awvalid && axi.awready) begin m_aw_h = 1'b1; m_idx = axi.awaddr[3:2]; end
         if (axi.wvalid && axi.wready) begin m_w_h = 1'b1; m_data = axi.wdata; m_strb = axi.wstrb; end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("obj_regs", obj_regs, exp_obj());
         check("obj_wr_pulse", 128'(obj_wr_pulse), 128'(m_pulse));
         check("bvalid", 128'(axi.bvalid), 128'(m_bv));
         check("rvalid", 128'(axi.rvalid), 128'(m_rv));
         if (m_rv) check("rdata", 128'(axi.rdata), 128'(m_rd));
         if (axi.bvalid) check("bresp", 128'(axi.bresp), 128'(2'b00));
         if (axi.rvalid) check("rresp", 128'(axi.rresp), 128'(2'b00));
      end
   end

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int  n;
      logic aw_f, w_f;
      n = 0;
      @(negedge clk);
      axi.awaddr = a; axi.awvalid = 1'b1;
      axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
      while ((axi.awvalid || axi.wvalid) && n < 20) begin
         @(posedge clk);
         aw_f = axi.awvalid && axi.awready;
         w_f  = axi.wvalid && axi.wready;
         @(negedge clk);
         if (aw_f) axi.awvalid = 1'b0;
         if (w_f)  axi.wvalid = 1'b0;
         n++;
      end
      if (axi.awvalid || axi.wvalid) begin
         timeout_fail("write_aw_w");
         axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      end
      n = 0;
      while (!axi.bvalid && n < 20) begin @(negedge clk); n++; end
      if (!axi.bvalid) timeout_fail("write_bvalid");
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      int  n;
      logic ar_f;
      n = 0;
      ar_f = 1'b0;
      @(negedge clk);
      axi.araddr = a; axi.arvalid = 1'b1;
      while (axi.arvalid && n < 20) begin
         @(posedge clk);
         ar_f = axi.arready;
         @(negedge clk);
         if (ar_f) axi.arvalid = 1'b0;
         n++;
      end
      if (axi.arvalid) begin timeout_fail("read_ar"); axi.arvalid = 1'b0; end
      n = 0;
      while (!axi.rvalid && n < 20) begin @(negedge clk); n++; end
      if (!axi.rvalid) timeout_fail("read_rvalid");
      d = axi.rdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, held;
      logic        f;
      int          t0, t1, n, pc0;
      bit          bseen;
      logic [3:0]  addrs [4];
      addrs[0] = REG_PADDLE_L; addrs[1] = REG_PADDLE_R;
      addrs[2] = REG_BALL_X;   addrs[3] = REG_BALL_Y;

      axi.awaddr = 4'h0; axi.awprot = 3'b000; axi.awvalid = 1'b0;
      axi.wdata = 32'h0; axi.wstrb = 4'h0; axi.wvalid = 1'b0; axi.bready = 1'b1;
      axi.araddr = 4'h0; axi.arprot = 3'b000; axi.arvalid = 1'b0; axi.rready = 1'b1;

      #1 rst_n = 1'b0;
      #200;
      check("rst_awready", 128'(axi.awready), 128'(0));
      check("rst_wready", 128'(axi.wready), 128'(0));
      check("rst_arready", 128'(axi.arready), 128'(0));
      check("rst_bvalid", 128'(axi.bvalid), 128'(0));
      check("rst_rvalid", 128'(axi.rvalid), 128'(0));
      check("rst_rdata", 128'(axi.rdata), 128'(0));
      check("rst_obj_regs", obj_regs, 128'(0));
      check("rst_pulse", 128'(obj_wr_pulse), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_awready", 128'(axi.awready), 128'(1));
      check("post_rst_arready", 128'(axi.arready), 128'(1));

      // Basic write/readback of all four registers.
      for (int i = 0; i < 4; i++) axi_write(addrs[i], 32'(i + 1), 4'hF);
      for (int i = 0; i < 4; i++) begin
         axi_read(addrs[i], rd);
         check("readback_basic", 128'(rd), 128'(i + 1));
      end

      // W arrives three cycles before AW.
      @(negedge clk);
      axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      @(posedge clk);
      f = axi.wready;
      @(negedge clk);
      axi.wvalid = 1'b0;
      check("w_first_hs", 128'(f), 128'(1));
      repeat (2) @(negedge clk);
      check("w_held_wready", 128'(axi.wready), 128'(0));
      check("w_held_awready", 128'(axi.awready), 128'(1));
      axi.awaddr = REG_BALL_X; axi.awvalid = 1'b1;
      @(posedge clk);
      f = axi.awready;
      t0 = cyc;
      @(negedge clk);
      axi.awvalid = 1'b0;
      check("aw_late_hs", 128'(f), 128'(1));
      bseen = 0; n = 0; t1 = 0;
      while (!bseen && n < 10) begin
         @(posedge clk);
         if (axi.bvalid) begin bseen = 1; t1 = cyc; end
         n++;
      end
      if (!bseen) timeout_fail("w_first_bvalid");
      else check("b_latency", 128'(t1 - t0), 128'(2));
      axi_read(REG_BALL_X, rd);
      check("readback_w_first", 128'(rd), 128'(32'hDEADBEEF));

      // Byte-lane merge and single-cycle write pulse.
      pc0 = pulse_cnt;
      axi_write(REG_PADDLE_R, 32'hAABBCCDD, 4'hF);
      @(negedge clk);
      check("pulse_count_full", 128'(pulse_cnt - pc0), 128'(1));
      check("pulse_bit_full", 128'(last_pulse), 128'(4'b0010));
      pc0 = pulse_cnt;
      axi_write(REG_PADDLE_R, 32'h00001100, 4'b0010);
      @(negedge clk);
      check("pulse_count_strb", 128'(pulse_cnt - pc0), 128'(1));
      check("pulse_bit_strb", 128'(last_pulse), 128'(4'b0010));
      axi_read(REG_PADDLE_R, rd);
      check("readback_strb", 128'(rd), 128'(32'hAABB11DD));
      axi_write(REG_BALL_Y, 32'hFFFFFFFF, 4'h0);
      axi_read(REG_BALL_Y, rd);
      check("readback_strb_zero", 128'(rd), 128'(32'h4));

      // Stalled responses, with a read colliding with the commit.
      @(negedge clk);
      axi.bready = 1'b0; axi.rready = 1'b0;
      axi.awaddr = REG_PADDLE_R; axi.wdata = 32'h12345678; axi.wstrb = 4'hF;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      @(posedge clk);
      f = axi.awready & axi.wready;
      @(negedge clk);
      check("stall_aw_w_hs", 128'(f), 128'(1));
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      axi.araddr = REG_PADDLE_R; axi.arvalid = 1'b1;
      @(posedge clk);
      f = axi.arready;
      @(negedge clk);
      axi.arvalid = 1'b0;
      check("stall_ar_hs", 128'(f), 128'(1));
      check("collision_rdata", 128'(axi.rdata), 128'(32'hAABB11DD));
      held = axi.rdata;
      repeat (10) begin
         @(negedge clk);
         check("stall_bvalid", 128'(axi.bvalid), 128'(1));
         check("stall_rvalid", 128'(axi.rvalid), 128'(1));
         check("stall_awready", 128'(axi.awready), 128'(0));
         check("stall_wready", 128'(axi.wready), 128'(0));
         check("stall_arready", 128'(axi.arready), 128'(0));
         check("stall_rdata", 128'(axi.rdata), 128'(held));
      end
      axi.bready = 1'b1; axi.rready = 1'b1;
      @(negedge clk);
      check("unstall_bvalid", 128'(axi.bvalid), 128'(0));
      check("unstall_rvalid", 128'(axi.rvalid), 128'(0));
      axi_read(REG_PADDLE_R, rd);
      check("readback_after_stall", 128'(rd), 128'(32'h12345678));

      // Shadow/live presentation of obj_regs.
      axi_write(REG_PADDLE_L, 32'h55, 4'hF);
      @(negedge clk);
`ifdef GAME_OBJ_SHADOW_EN
      check("shadow_before_tick", 128'(obj_regs[31:0]), 128'(0));
`else
      check("live_obj_reg0", 128'(obj_regs[31:0]), 128'(32'h55));
`endif
      axi_read(REG_PADDLE_L, rd);
      check("readback_0x55", 128'(rd), 128'(32'h55));
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      check("obj_reg0_after_tick", 128'(obj_regs[31:0]), 128'(32'h55));

      // Reset while AW is held and RVALID is pending.
      @(negedge clk);
      axi.rready = 1'b0;
      axi.awaddr = REG_BALL_Y; axi.awvalid = 1'b1; axi.wvalid = 1'b0;
      axi.araddr = REG_BALL_X; axi.arvalid = 1'b1;
      @(negedge clk);
      axi.awvalid = 1'b0; axi.arvalid = 1'b0;
      check("pre_rst_rvalid", 128'(axi.rvalid), 128'(1));
      check("pre_rst_awready", 128'(axi.awready), 128'(0));
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_awready", 128'(axi.awready), 128'(0));
      check("mid_rst_wready", 128'(axi.wready), 128'(0));
      check("mid_rst_arready", 128'(axi.arready), 128'(0));
      check("mid_rst_bvalid", 128'(axi.bvalid), 128'(0));
      check("mid_rst_rvalid", 128'(axi.rvalid), 128'(0));
      check("mid_rst_rdata", 128'(axi.rdata), 128'(0));
      check("mid_rst_obj_regs", obj_regs, 128'(0));
      check("mid_rst_pulse", 128'(obj_wr_pulse), 128'(0));
      axi.rready = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("post_rst_no_bvalid", 128'(axi.bvalid), 128'(0));
         check("post_rst_no_rvalid", 128'(axi.rvalid), 128'(0));
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(addrs[i], rd);
         check("readback_after_reset", 128'(rd), 128'(0));
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
